fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameter values for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   localparam int DEF_NREQ       = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   int pos;

   // Walk the offsets from the far end back to zero so the closest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = int'(start) + k;
         if (pos >= N) pos = pos - N;
         if (req[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one synchronous FIFO.
// Define ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_w_en,
   output logic [DATA_WIDTH-1:0]      fifo_data,
   output logic [$clog2(NREQ)-1:0]    grant_id
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ must be 2..16");
   end
   if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
      $error("fifo_wr_arbiter: BURST_LEN must be 1..255");
   end

   logic [IW-1:0] last_grant;
   logic [IW-1:0] start;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic [IW-1:0] winner;
   logic          found;

   assign start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .req   (req_valid),
      .start (start),
      .found (pick_found),
      .idx   (pick_idx)
   );

`ifdef ARB_BURST_EN
   arb_state_t state;
   logic [7:0] burst_cnt;
   logic       held_on;

   // The held requester keeps the grant only while it still asks for it.
   assign held_on = (state == HOLD) && req_valid[last_grant];
   assign winner  = held_on ? last_grant : pick_idx;
   assign found   = held_on | pick_found;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= LAST_IDX;
         state      <= IDLE;
         burst_cnt  <= '0;
      end else if (fifo_w_en) begin
         last_grant <= winner;
         if (held_on) begin
            if (burst_cnt + 8'd1 == 8'(BURST_LEN)) begin
               state     <= IDLE;
               burst_cnt <= '0;
            end else begin
               burst_cnt <= burst_cnt + 8'd1;
            end
         end else if (BURST_LEN > 1) begin
            state     <= HOLD;
            burst_cnt <= 8'd1;
         end else begin
            state     <= IDLE;
            burst_cnt <= '0;
         end
      end else if (!fifo_full && state == HOLD && !req_valid[last_grant]) begin
         state     <= IDLE;
         burst_cnt <= '0;
      end
   end
`else
   assign winner = pick_idx;
   assign found  = pick_found;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= LAST_IDX;
      end else if (fifo_w_en) begin
         last_grant <= winner;
      end
   end
`endif

   // Ready goes to the winner alone, and only when a beat can really land.
   always_comb begin
      req_ready = '0;
      if (found && rst_n && !fifo_full) req_ready[winner] = 1'b1;
   end

   assign fifo_w_en = |(req_valid & req_ready);
   assign fifo_data = found ? req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign grant_id  = winner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a round-robin reference model.
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int BL   = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]  req_ready;
   logic             fifo_full;
   logic             fifo_w_en;
   logic [DW-1:0]    fifo_data;
   logic [1:0]       grant_id;

   int tests_run    = 0;
   int tests_failed = 0;

   int         m_last = NREQ - 1;
   int         m_held = -1;
   int         m_cnt  = 0;
   logic [7:0] m_data [NREQ];
   logic [3:0] cur_v;
   logic       cur_full;
   logic       cur_rstn;
   int         exp_win;
   logic       exp_wen;
   logic [3:0] exp_ready;
   logic [7:0] exp_data;
   logic [1:0] exp_gid;

   fifo_wr_arbiter #(
      .NREQ       (NREQ),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_w_en (fifo_w_en),
      .fifo_data (fifo_data),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   // Expected outputs for the current inputs, from the arbitration rules.
   task automatic model_eval();
      exp_win = -1;
`ifdef ARB_BURST_EN
      if (m_held >= 0 && cur_v[m_held]) exp_win = m_held;
`endif
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (m_last + k) % NREQ;
         if (exp_win < 0 && cur_v[j]) exp_win = j;
      end
      exp_wen   = cur_rstn && !cur_full && (exp_win >= 0);
      exp_ready = exp_wen ? 4'(1 << exp_win) : 4'b0;
      exp_data  = (exp_win >= 0) ? m_data[exp_win] : 8'h00;
      exp_gid   = (exp_win >= 0) ? 2'(exp_win) : 2'd0;
   endtask

   task automatic model_commit();
      if (!cur_rstn) begin
         m_last = NREQ - 1;
         m_held = -1;
         m_cnt  = 0;
      end else if (exp_wen) begin
`ifdef ARB_BURST_EN
         if (exp_win == m_held) begin
            m_cnt++;
            if (m_cnt == BL) begin
               m_held = -1;
               m_cnt  = 0;
            end
         end else if (BL > 1) begin
            m_held = exp_win;
            m_cnt  = 1;
         end else begin
            m_held = -1;
            m_cnt  = 0;
         end
`endif
         m_last = exp_win;
      end else if (!cur_full && m_held >= 0 && !cur_v[m_held]) begin
         m_held = -1;
         m_cnt  = 0;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic full, input logic rstn);
      for (int i = 0; i < NREQ; i++) begin
         m_data[i] = 8'($urandom);
         req_data[i*DW +: DW] = m_data[i];
      end
      req_valid = v;
      fifo_full = full;
      rst_n     = rstn;
      cur_v     = v;
      cur_full  = full;
      cur_rstn  = rstn;
      model_eval();
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0);
         tests_run++;
         if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset cycle %0d: ready=%b wen=%b, want ready=0000 wen=0",
                     c, req_ready, fifo_w_en);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      int seq [5];
`ifdef ARB_BURST_EN
      seq = '{0, 0, 0, 0, 1};
`else
      seq = '{0, 1, 2, 3, 0};
`endif
      applyStimulus(4'b1111, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         tests_run++;
         if (req_ready !== exp_ready || fifo_w_en !== 1'b1 || grant_id !== 2'(seq[c])
             || fifo_data !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL rr cycle %0d: ready=%b wen=%b gid=%0d data=%h, want ready=%b wen=1 gid=%0d data=%h",
                     c, req_ready, fifo_w_en, grant_id, fifo_data, exp_ready, seq[c], exp_data);
         end
         tick();
      end
   endtask

   task automatic test_sparse();
      int seq [4];
`ifdef ARB_BURST_EN
      seq = '{1, 1, 1, 1};
`else
      seq = '{1, 3, 1, 3};
`endif
      applyStimulus(4'b1010, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b1010, 1'b0, 1'b1);
         tests_run++;
         if (fifo_w_en !== 1'b1 || grant_id !== 2'(seq[c]) || req_ready[0] !== 1'b0
             || req_ready[2] !== 1'b0 || fifo_data !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL sparse cycle %0d: ready=%b wen=%b gid=%0d data=%h, want wen=1 gid=%0d data=%h",
                     c, req_ready, fifo_w_en, grant_id, fifo_data, seq[c], exp_data);
         end
         tick();
      end
   endtask

   task automatic test_full_stall();
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b0100, 1'b1, 1'b1);
         tests_run++;
         if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall cycle %0d: ready=%b wen=%b, want ready=0000 wen=0",
                     c, req_ready, fifo_w_en);
         end
         tick();
      end
      applyStimulus(4'b0100, 1'b0, 1'b1);
      tests_run++;
      if (req_ready !== 4'b0100 || fifo_w_en !== 1'b1 || grant_id !== 2'd2
          || fifo_data !== m_data[2]) begin
         tests_failed++;
         $display("[TB] FAIL stall release: ready=%b wen=%b gid=%0d data=%h, want ready=0100 wen=1 gid=2 data=%h",
                  req_ready, fifo_w_en, grant_id, fifo_data, m_data[2]);
      end
      tick();
   endtask

   task automatic test_idle();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b0000, c[0], 1'b1);
         tests_run++;
         if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0 || fifo_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL idle cycle %0d: ready=%b wen=%b data=%h, want 0000/0/00",
                     c, req_ready, fifo_w_en, fifo_data);
         end
         tick();
      end
   endtask

   task automatic test_reset_midburst();
      applyStimulus(4'b1111, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         tick();
      end
      applyStimulus(4'b1111, 1'b0, 1'b0);
      tests_run++;
      if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midburst reset: ready=%b wen=%b, want ready=0000 wen=0",
                  req_ready, fifo_w_en);
      end
      tick();
      applyStimulus(4'b1111, 1'b0, 1'b1);
      tests_run++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
         tests_failed++;
         $display("[TB] FAIL post-reset grant: ready=%b wen=%b gid=%0d, want ready=0001 wen=1 gid=0",
                  req_ready, fifo_w_en, grant_id);
      end
      tick();
   endtask

`ifdef ARB_BURST_EN
   task automatic test_burst();
      int seq [9];
      seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      applyStimulus(4'b0011, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 9; c++) begin
         applyStimulus(4'b0011, 1'b0, 1'b1);
         tests_run++;
         if (fifo_w_en !== 1'b1 || grant_id !== 2'(seq[c])) begin
            tests_failed++;
            $display("[TB] FAIL burst cycle %0d: wen=%b gid=%0d, want wen=1 gid=%0d",
                     c, fifo_w_en, grant_id, seq[c]);
         end
         tick();
      end
   endtask

   task automatic test_burst_drop();
      applyStimulus(4'b0011, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b0011, 1'b0, 1'b1);
         tick();
      end
      applyStimulus(4'b0010, 1'b0, 1'b1);
      tests_run++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL burst drop: ready=%b wen=%b gid=%0d, want ready=0010 wen=1 gid=1",
                  req_ready, fifo_w_en, grant_id);
      end
      tick();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         applyStimulus(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) != 0));
         tests_run++;
         if (req_ready !== exp_ready || fifo_w_en !== exp_wen || fifo_data !== exp_data
             || (exp_wen && grant_id !== exp_gid)) begin
            tests_failed++;
            $display("[TB] FAIL random cycle %0d: ready=%b wen=%b gid=%0d data=%h, want ready=%b wen=%b gid=%0d data=%h",
                     c, req_ready, fifo_w_en, grant_id, fifo_data, exp_ready, exp_wen, exp_gid, exp_data);
         end
         tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_sparse();
      test_full_stall();
      test_idle();
      test_reset_midburst();
`ifdef ARB_BURST_EN
      test_burst();
      test_burst_drop();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
